subleq_memory: RTL

//   Synthesizable byte-wide memory that responds to the subleq core's bus: the

---
 rtl/subleq_memory_if.sv | 41 ++++
 rtl/subleq_memory.sv | 114 +++++++++++
 2 files changed

// File: rtl/subleq_memory_if.sv
// subleq_memory_if
//   Bundles the signals between the subleq memory and its users: the core
//   bus, the byte-serial program loader, and the debug peek port.
//   master : drives addresses, write words and loader bytes (core/loader/bench)
//   slave  : the memory itself, returning read data and status
//   Signals:
//     read        core read address
//     write       core write word, {value, address}
//     data        registered read data to the core
//     core_enable high only while the core may run
//     load_valid  program byte offered
//     load_data   program byte
//     load_ready  memory is accepting program bytes
//     load_done   loader has finished
//     dbg_addr    peek address
//     dbg_data    registered word at dbg_addr
interface subleq_memory_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]            read;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] write;
    logic [DATA_WIDTH-1:0]            data;
    logic                             core_enable;
    logic                             load_valid;
    logic [DATA_WIDTH-1:0]            load_data;
    logic                             load_ready;
    logic                             load_done;
    logic [ADDR_WIDTH-1:0]            dbg_addr;
    logic [DATA_WIDTH-1:0]            dbg_data;

    modport master (
        output read, write, load_valid, load_data, load_done, dbg_addr,
        input  data, core_enable, load_ready, dbg_data
    );

    modport slave (
        input  read, write, load_valid, load_data, load_done, dbg_addr,
        output data, core_enable, load_ready, dbg_data
    );
endinterface

// File: rtl/subleq_memory.sv
// subleq_memory
//   Byte-wide memory serving the subleq core. After reset it zero-fills the
//   whole array, then accepts a byte-serial program load, then enables the
//   core. In RUN it returns mem[read] one cycle later and commits the core's
//   {value, address} write word on every clock edge.
//   Ports:
//     clock    rising-edge system clock
//     reset_n  asynchronous active-low reset
//     bus      subleq_memory_if slave modport (core bus, loader, debug peek)
module subleq_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    subleq_memory_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  load_accept;

    assign load_accept     = bus.load_valid && (state == LOAD);
    assign bus.core_enable = (state == RUN);
    assign bus.load_ready  = (state == LOAD);

    // Next state plus the single array write port; exactly one writer is
    // selected by the current state so the three sources never collide.
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
                if (clr_addr == '1) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (load_accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = load_addr;
                    mem_wdata = bus.load_data;
                end
                // Filling the last word ends the load so load_addr never wraps
                // back over the start of the program.
                if (bus.load_done || (load_accept && (load_addr == '1))) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                mem_we    = 1'b1;
                mem_waddr = bus.write[ADDR_WIDTH-1:0];
                mem_wdata = bus.write[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            load_addr <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (load_accept) begin
                load_addr <= load_addr + 1'b1;
            end
        end
    end

    // The array has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read ports sample the array before this edge's write lands, so a same
    // address read/write returns the old value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.data     <= '0;
            bus.dbg_data <= '0;
        end else begin
            bus.data     <= (state == RUN) ? mem[bus.read] : '0;
            bus.dbg_data <= mem[bus.dbg_addr];
        end
    end
endmodule
